// File: rtl/pipe_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, talks to a variable-latency instruction
// memory, holds a fetched instruction across stalls and remembers redirects seen while stalled.
module pipe_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        wpcir,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic        imem_rdy,
  input  logic [31:0] imem_ins,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic [31:0] ins,
  output logic        ins_valid,
  output logic [15:0] wait_cnt
);

  typedef enum logic [1:0] {StBoot, StReq, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] pending_target_q, pending_target_d;
  logic        pending_valid_q, pending_valid_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;

  logic        advance;
  logic [31:0] live_target;
  logic [31:0] npc;

  assign pc        = pc_q;
  assign pc4       = pc_q + 32'd4;
  assign imem_addr = pc_q;
  assign wait_cnt  = wait_cnt_q;
  assign advance   = ins_valid & wpcir;

  // Output decode and state transitions
  always_comb begin
    imem_req  = 1'b0;
    ins       = '0;
    ins_valid = 1'b0;
    state_d   = state_q;
    hold_d    = hold_q;
    unique case (state_q)
      StBoot: begin
        state_d = StReq;
      end
      StReq: begin
        imem_req  = 1'b1;
        ins       = imem_ins;
        ins_valid = imem_rdy;
        // Data arrived but ID is stalled: park it so memory can be released.
        if (imem_rdy && !wpcir) begin
          hold_d  = imem_ins;
          state_d = StHold;
        end
      end
      StHold: begin
        ins       = hold_q;
        ins_valid = 1'b1;
        if (wpcir) begin
          state_d = StReq;
        end
      end
      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_comb begin
    unique case (pcsrc)
      2'b01:   live_target = bpc;
      2'b10:   live_target = rpc;
      2'b11:   live_target = jpc;
      default: live_target = pc4;
    endcase
  end

  // A live redirect wins over a remembered one; the remembered one wins over sequential flow.
  always_comb begin
    if (pcsrc != 2'b00) begin
      npc = live_target;
    end else if (pending_valid_q) begin
      npc = pending_target_q;
    end else begin
      npc = pc4;
    end
  end

  always_comb begin
    pc_d             = pc_q;
    pending_valid_d  = pending_valid_q;
    pending_target_d = pending_target_q;
    if (advance) begin
      pc_d            = npc;
      pending_valid_d = 1'b0;
    end else if (pcsrc != 2'b00) begin
      pending_valid_d  = 1'b1;
      pending_target_d = live_target;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == StReq && !imem_rdy && wait_cnt_q != 16'hFFFF) begin
      wait_cnt_d = wait_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q          <= StBoot;
      pc_q             <= RESET_PC;
      hold_q           <= '0;
      pending_valid_q  <= 1'b0;
      pending_target_q <= '0;
      wait_cnt_q       <= '0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      hold_q           <= hold_d;
      pending_valid_q  <= pending_valid_d;
      pending_target_q <= pending_target_d;
      wait_cnt_q       <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_fetch_ctrl.sv
// Directed bench for pipe_fetch_ctrl: inputs change on the falling edge, outputs are
// checked 1ns later, well away from the rising edge.
module tb_pipe_fetch_ctrl;

  logic        clk;
  logic        clrn;
  logic        wpcir;
  logic [1:0]  pcsrc;
  logic [31:0] bpc, rpc, jpc;
  logic        imem_rdy;
  logic [31:0] imem_ins;
  logic        imem_req;
  logic [31:0] imem_addr, pc, pc4, ins;
  logic        ins_valid;
  logic [15:0] wait_cnt;

  int n_cmp;
  int n_err;

  pipe_fetch_ctrl #(
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk      (clk),
    .clrn     (clrn),
    .wpcir    (wpcir),
    .pcsrc    (pcsrc),
    .bpc      (bpc),
    .rpc      (rpc),
    .jpc      (jpc),
    .imem_rdy (imem_rdy),
    .imem_ins (imem_ins),
    .imem_req (imem_req),
    .imem_addr(imem_addr),
    .pc       (pc),
    .pc4      (pc4),
    .ins      (ins),
    .ins_valid(ins_valid),
    .wait_cnt (wait_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    clrn = 1'b0; wpcir = 1'b1; pcsrc = 2'b00; bpc = '0; rpc = '0; jpc = '0;
    imem_rdy = 1'b1; imem_ins = 32'h1111_0000;
    tick(); #1;
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    n_cmp++; if (pc4 !== 32'h4) begin n_err++; $display("FAIL reset_pc4: got %h want %h", pc4, 32'h4); end
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_cmp++; if (ins_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", ins_valid); end
    n_cmp++; if (ins !== 32'h0) begin n_err++; $display("FAIL reset_ins: got %h want 0", ins); end
    n_cmp++; if (wait_cnt !== 16'h0) begin n_err++; $display("FAIL reset_wait: got %h want 0", wait_cnt); end
  endtask

  // Release reset, one BOOT cycle, then one instruction per cycle at 0,4,8.
  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    tick(); clrn = 1'b1; #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL boot_req: got %b want 0", imem_req); end
    exp_pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick(); imem_ins = 32'h1111_0000 | exp_pc; #1;
      n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc, exp_pc); end
      n_cmp++; if (ins_valid !== 1'b1) begin n_err++; $display("FAIL seq_valid[%0d]: got %b want 1", i, ins_valid); end
      n_cmp++; if (ins !== (32'h1111_0000 | exp_pc)) begin n_err++; $display("FAIL seq_ins[%0d]: got %h want %h", i, ins, 32'h1111_0000 | exp_pc); end
      n_cmp++; if (imem_addr !== exp_pc) begin n_err++; $display("FAIL seq_addr[%0d]: got %h want %h", i, imem_addr, exp_pc); end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  // pc=8: memory busy for 3 cycles, then delivers.
  task automatic test_wait();
    imem_rdy = 1'b0;
    repeat (3) tick();
    #1;
    n_cmp++; if (pc !== 32'h8) begin n_err++; $display("FAIL wait_pc: got %h want %h", pc, 32'h8); end
    n_cmp++; if (ins_valid !== 1'b0) begin n_err++; $display("FAIL wait_valid: got %b want 0", ins_valid); end
    n_cmp++; if (wait_cnt !== 16'd3) begin n_err++; $display("FAIL wait_cnt: got %0d want 3", wait_cnt); end
    imem_rdy = 1'b1;
    tick(); #1;
    n_cmp++; if (pc !== 32'hC) begin n_err++; $display("FAIL wait_resume_pc: got %h want %h", pc, 32'hC); end
  endtask

  // Advance to pc=0x10, then stall ID for 2 cycles with data ready.
  task automatic test_hold();
    tick(); #1;
    n_cmp++; if (pc !== 32'h10) begin n_err++; $display("FAIL hold_start_pc: got %h want %h", pc, 32'h10); end
    wpcir = 1'b0; imem_ins = 32'h0000_AABB;
    tick(); imem_ins = 32'h0000_1234; #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL hold_req: got %b want 0", imem_req); end
    n_cmp++; if (ins !== 32'h0000_AABB) begin n_err++; $display("FAIL hold_ins: got %h want %h", ins, 32'hAABB); end
    n_cmp++; if (ins_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid: got %b want 1", ins_valid); end
    tick(); #1;
    n_cmp++; if (ins !== 32'h0000_AABB) begin n_err++; $display("FAIL hold2_ins: got %h want %h", ins, 32'hAABB); end
    n_cmp++; if (pc !== 32'h10) begin n_err++; $display("FAIL hold2_pc: got %h want %h", pc, 32'h10); end
    wpcir = 1'b1;
    tick(); #1;
    n_cmp++; if (pc !== 32'h14) begin n_err++; $display("FAIL hold_exit_pc: got %h want %h", pc, 32'h14); end
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL hold_exit_req: got %b want 1", imem_req); end
  endtask

  // pc=0x24 waits 2 cycles while a branch to 0x100 is signalled; delay slot still delivered.
  task automatic test_redirect();
    repeat (4) tick();
    #1;
    n_cmp++; if (pc !== 32'h24) begin n_err++; $display("FAIL redir_start_pc: got %h want %h", pc, 32'h24); end
    imem_rdy = 1'b0; pcsrc = 2'b01; bpc = 32'h100;
    repeat (2) tick();
    pcsrc = 2'b00; bpc = 32'h0; imem_rdy = 1'b1; imem_ins = 32'h000D_E1A7; #1;
    n_cmp++; if (pc !== 32'h24) begin n_err++; $display("FAIL redir_slot_pc: got %h want %h", pc, 32'h24); end
    n_cmp++; if (ins !== 32'h000D_E1A7 || ins_valid !== 1'b1) begin n_err++; $display("FAIL redir_slot_ins: got %h/%b want %h/1", ins, ins_valid, 32'hDE1A7); end
    n_cmp++; if (wait_cnt !== 16'd5) begin n_err++; $display("FAIL redir_wait: got %0d want 5", wait_cnt); end
    tick(); #1;
    n_cmp++; if (pc !== 32'h100) begin n_err++; $display("FAIL redir_target_pc: got %h want %h", pc, 32'h100); end
    // Pending must be gone, so the next advance is sequential.
    tick(); #1;
    n_cmp++; if (pc !== 32'h104) begin n_err++; $display("FAIL redir_cleared_pc: got %h want %h", pc, 32'h104); end
  endtask

  // Jump on the advance cycle, then memory stuck long enough to saturate wait_cnt.
  task automatic test_jump_saturate();
    pcsrc = 2'b11; jpc = 32'h40;
    tick(); pcsrc = 2'b00; jpc = 32'h0; #1;
    n_cmp++; if (pc !== 32'h40) begin n_err++; $display("FAIL jump_pc: got %h want %h", pc, 32'h40); end
    imem_rdy = 1'b0;
    repeat (70000) tick();
    #1;
    n_cmp++; if (wait_cnt !== 16'hFFFF) begin n_err++; $display("FAIL wait_sat: got %h want %h", wait_cnt, 16'hFFFF); end
    n_cmp++; if (pc !== 32'h40) begin n_err++; $display("FAIL sat_pc: got %h want %h", pc, 32'h40); end
  endtask

  // Enter HOLD at 0x40, record a jr redirect, then reset mid-HOLD.
  task automatic test_reset_in_hold();
    imem_rdy = 1'b1; wpcir = 1'b0; imem_ins = 32'h0000_0040;
    tick(); pcsrc = 2'b10; rpc = 32'h200;
    tick(); pcsrc = 2'b00; rpc = 32'h0; #1;
    n_cmp++; if (imem_req !== 1'b0 || ins !== 32'h40) begin n_err++; $display("FAIL rh_hold: got req=%b ins=%h want req=0 ins=40", imem_req, ins); end
    #2; clrn = 1'b0; #1;
    n_cmp++; if (pc !== 32'h0 || ins !== 32'h0 || ins_valid !== 1'b0 || wait_cnt !== 16'h0 || imem_req !== 1'b0) begin
      n_err++; $display("FAIL rh_async: got pc=%h ins=%h v=%b wc=%h req=%b want all 0", pc, ins, ins_valid, wait_cnt, imem_req);
    end
    wpcir = 1'b1;
    tick(); clrn = 1'b1;
    tick(); #1;
    n_cmp++; if (pc !== 32'h0 || imem_req !== 1'b1) begin n_err++; $display("FAIL rh_first_req: got pc=%h req=%b want 0/1", pc, imem_req); end
    tick(); #1;
    n_cmp++; if (pc !== 32'h4) begin n_err++; $display("FAIL rh_no_pending: got %h want %h", pc, 32'h4); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_back_to_back();
    test_wait();
    test_hold();
    test_redirect();
    test_jump_saturate();
    test_reset_in_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_fetch_ctrl.md
PIPE_FETCH_CTRL -- requirements
Module: pipe_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 clrn  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 wpcir  input  1  SHALL be the PC write enable from the hazard unit; 0 = pipeline stall.
REQ-005 pcsrc  input  2  SHALL be the next-PC select from ID: 00 pc+4, 01 bpc, 10 rpc, 11 jpc.
REQ-006 bpc, rpc, jpc  input  32 each  SHALL be the branch, jr and j/jal targets.
REQ-007 imem_rdy  input  1  SHALL indicate that imem_ins is valid for the current request this cycle.
REQ-008 imem_ins  input  32  SHALL be the instruction-memory read data.
REQ-009 imem_req  output  1  SHALL request a fetch at imem_addr.
REQ-010 imem_addr  output  32  SHALL equal pc.
REQ-011 pc, pc4  output  32 each  SHALL be the current fetch PC and pc+4 (modulo 2^32).
REQ-012 ins  output  32  SHALL be the delivered instruction; ins_valid  output  1  SHALL qualify it.
REQ-013 wait_cnt  output  16  SHALL count memory wait cycles.

Function
REQ-014 The FSM SHALL have three states: BOOT, REQ and HOLD.
REQ-015 BOOT SHALL drive imem_req=0 and ins_valid=0, and SHALL go to REQ unconditionally on the next edge.
REQ-016 REQ SHALL drive imem_req=1 and ins=imem_ins (combinational), with ins_valid=imem_rdy.
REQ-017 In REQ with imem_rdy=1 and wpcir=0, the block SHALL capture imem_ins into the hold buffer and go to HOLD.
REQ-018 HOLD SHALL drive imem_req=0, ins=hold buffer and ins_valid=1, and SHALL stay in HOLD until wpcir=1.
REQ-019 advance SHALL be defined as ins_valid & wpcir; on advance, pc SHALL load npc and the state SHALL become REQ.
REQ-020 When not advancing, pc SHALL hold; pc SHALL never change while imem_req=1 and imem_rdy=0.
REQ-021 npc SHALL be selected as follows: pcsrc!=00 selects the live target; else pending_valid selects pending_target; else pc4.
REQ-022 In any non-advance cycle with pcsrc!=00, the block SHALL latch the selected target into pending_target and set pending_valid.
REQ-023 If a later non-advance cycle has a different nonzero pcsrc, the latest pcsrc SHALL overwrite pending_target.
REQ-024 pending_valid SHALL clear on every advance.
REQ-025 The instruction in flight when a redirect arrives (the delay slot) SHALL still be delivered; no squash is performed.
REQ-026 Advance in the same cycle as a redirect SHALL use the live target with single-cycle latency; the new pc is requested on the next cycle.
REQ-027 wait_cnt SHALL increment in each cycle with state REQ and imem_rdy=0.
REQ-028 wait_cnt SHALL saturate at 16'hFFFF and SHALL never wrap.
REQ-029 Back-to-back advances with imem_rdy held at 1 SHALL sustain one instruction per cycle.

Reset
REQ-030 While clrn=0, the block SHALL force pc=RESET_PC, state=BOOT, pending_valid=0, hold buffer=0 and wait_cnt=0 immediately.
REQ-031 The resulting outputs SHALL be imem_req=0, ins_valid=0, ins=0 and pc4=RESET_PC+4.
REQ-032 Reset asserted mid-wait or mid-HOLD SHALL discard the in-flight fetch and pending redirect; the first request after release SHALL be to RESET_PC one cycle after BOOT.

Verification
REQ-033 Reset release, imem_rdy=1, wpcir=1, pcsrc=00 -> BOOT one cycle, then pc SHALL be 0,4,8,C on consecutive cycles with ins_valid=1 each cycle.
REQ-034 imem_rdy=0 for 3 cycles at pc=8 -> pc SHALL hold at 8, ins_valid=0 and wait_cnt=3; on the 4th cycle with imem_rdy=1, pc SHALL become C.
REQ-035 pc=10, imem_rdy=1, wpcir=0 for 2 cycles with imem_ins=0xAABB -> state SHALL be HOLD, imem_req=0 and ins=0xAABB; when wpcir rises, pc SHALL become 14.
REQ-036 pcsrc=01, bpc=0x100 during the 2-cycle wait at pc=24, then pcsrc=00 at advance -> the delay-slot instruction at 24 SHALL be delivered, next pc SHALL be 0x100 and pending_valid SHALL be 0.
REQ-037 pcsrc=11, jpc=0x40 on the advance cycle -> next pc SHALL be 0x40; with imem_rdy stuck at 0 for 70000 cycles, wait_cnt SHALL equal 0xFFFF.
REQ-038 clrn pulsed low during HOLD with pending_valid=1 -> all state SHALL be cleared and the first request after release SHALL be to RESET_PC.
